snake_renderer: RTL

SNAKE_RENDERER -- requirements
Module: snake_renderer

---
 rtl/snake_renderer_if.sv | 27 ++
 rtl/snake_renderer.sv | 107 ++++++++++
 2 files changed

// File: rtl/snake_renderer_if.sv
// Pixel-side bus of the snake renderer: timing-generator inputs, grid RAM read port and VGA outputs.
// master drives the timing inputs and RAM data; slave is the renderer itself.
interface snake_renderer_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       video_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [8:0] cell_addr;
  logic [1:0] cell_data;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output hcount, vcount, video_on, hsync_in, vsync_in, cell_data,
    input  cell_addr, vga_r, vga_g, vga_b, hsync, vsync, frame_tick
  );

  modport slave (
    input  hcount, vcount, video_on, hsync_in, vsync_in, cell_data,
    output cell_addr, vga_r, vga_g, vga_b, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/snake_renderer.sv
// Tile renderer for a snake game: maps each pixel to a grid cell, reads the cell and emits its colour.
// Latency 3 clk (address, RAM read, colour) with syncs delayed to match; free-running, no backpressure.
module snake_renderer #(
  parameter int CELL_SHIFT   = 5,
  parameter int GRID_W       = 20,
  parameter int GRID_H       = 15,
  parameter int BLINK_FRAMES = 16
) (
  input  logic            clk,
  input  logic            rst,
  snake_renderer_if.slave vid
);
  localparam logic [9:0]       TICK_LINE = 10'd480;
  localparam int               CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [8:0]       GRID_W9   = 9'(GRID_W);
  localparam logic [8:0]       GRID_H9   = 9'(GRID_H);

  logic [8:0]       col;
  logic [8:0]       row;
  logic [8:0]       addr;
  logic             wall;
  logic             tick_now;
  logic [11:0]      rgb_next;

  logic             vis1, wall1, hs1, vs1;
  logic             vis2, wall2, hs2, vs2;
  logic [CNT_W-1:0] frame_cnt;
  logic             phase;

  // Row-major cell index; with GRID_W=20 this is (row<<4)+(row<<2)+col.
  always_comb begin
    col      = 9'(vid.hcount >> CELL_SHIFT);
    row      = 9'(vid.vcount >> CELL_SHIFT);
    addr     = row * GRID_W9 + col;
    wall     = (row == 9'd0) || (row == GRID_H9 - 9'd1) ||
               (col == 9'd0) || (col == GRID_W9 - 9'd1);
    tick_now = (vid.hcount == 10'd0) && (vid.vcount == TICK_LINE);
  end

  // cell_data belongs to the pixel now in stage 2; wall overrides whatever the RAM holds.
  always_comb begin
    rgb_next = 12'h000;
    if (vis2) begin
      if (wall2) begin
        rgb_next = 12'h888;
      end else begin
        case (vid.cell_data)
          2'b10:   rgb_next = 12'h8F8;
          2'b01:   rgb_next = 12'h0F0;
          2'b11:   rgb_next = phase ? 12'h800 : 12'hF00;
          default: rgb_next = 12'h000;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vid.cell_addr  <= 9'd0;
      vis1           <= 1'b0;
      wall1          <= 1'b0;
      hs1            <= 1'b1;
      vs1            <= 1'b1;
      vis2           <= 1'b0;
      wall2          <= 1'b0;
      hs2            <= 1'b1;
      vs2            <= 1'b1;
      vid.vga_r      <= 4'd0;
      vid.vga_g      <= 4'd0;
      vid.vga_b      <= 4'd0;
      vid.hsync      <= 1'b1;
      vid.vsync      <= 1'b1;
      vid.frame_tick <= 1'b0;
      frame_cnt      <= '0;
      phase          <= 1'b0;
    end else begin
      // Blanked pixels read cell 0 so the RAM never sees an out-of-grid address.
      vid.cell_addr  <= vid.video_on ? addr : 9'd0;
      vis1           <= vid.video_on;
      wall1          <= vid.video_on & wall;
      hs1            <= vid.hsync_in;
      vs1            <= vid.vsync_in;

      vis2           <= vis1;
      wall2          <= wall1;
      hs2            <= hs1;
      vs2            <= vs1;

      vid.vga_r      <= rgb_next[11:8];
      vid.vga_g      <= rgb_next[7:4];
      vid.vga_b      <= rgb_next[3:0];
      vid.hsync      <= hs2;
      vid.vsync      <= vs2;

      vid.frame_tick <= tick_now;
      if (tick_now) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
endmodule
